// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for a 5-stage MIPS-subset datapath: ID decode, ID/EX/MEM/WB control bundles,
// load-use / RAW interlock, EX operand forwarding and PC redirect with wrong-path flushing.
module pipe_ctrl_unit #(
   parameter int REG_AW   = 5,
   parameter bit FWD_EN   = 1'b1,
   parameter int LINK_REG = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       id_instr,
   input  logic              ex_zero,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic [1:0]        pc_sel,
   output logic              id_extop,
   output logic              id_luiop,
   output logic              ex_alusrc,
   output logic [1:0]        ex_aluop,
   output logic              ex_slt,
   output logic              ex_link,
   output logic [REG_AW-1:0] ex_dst,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              mem_write,
   output logic              mem_read,
   output logic              wb_regwrite,
   output logic              wb_memtoreg,
   output logic [REG_AW-1:0] wb_dst
);

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
   localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_SLT = 6'h2A;

   typedef struct packed {
      logic              alusrc;
      logic [1:0]        aluop;
      logic              slt;
      logic              link;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              memtoreg;
      logic              beq;
      logic              jr;
      logic [REG_AW-1:0] dst;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
   } ex_t;

   typedef struct packed {
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              memtoreg;
      logic [REG_AW-1:0] dst;
   } mem_t;

   typedef struct packed {
      logic              regwrite;
      logic              memtoreg;
      logic [REG_AW-1:0] dst;
   } wb_t;

   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic              id_uses_rs, id_uses_rt, id_jump_op;
   ex_t               id_bundle, ex_d, ex_q;
   mem_t              mem_d, mem_q;
   wb_t               wb_d, wb_q;
   logic              ex_redirect, ex_hit, mem_hit, hazard, stall, id_jump;

   assign id_rs = REG_AW'(id_instr[25:21]);
   assign id_rt = REG_AW'(id_instr[20:16]);
   assign id_rd = REG_AW'(id_instr[15:11]);

   // R-type with a nonzero shamt field is not a legal addu/subu/slt/jr and falls to NOP.
   always_comb begin
      id_bundle  = '0;
      id_extop   = 1'b0;
      id_luiop   = 1'b0;
      id_uses_rs = 1'b0;
      id_uses_rt = 1'b0;
      id_jump_op = 1'b0;
      case (id_instr[31:26])
         OP_RTYPE: begin
            if (id_instr[10:6] == 5'd0) begin
               case (id_instr[5:0])
                  FN_ADDU: begin
                     id_extop = 1'b1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
                     id_bundle.aluop = 2'd3; id_bundle.regwrite = 1'b1; id_bundle.dst = id_rd;
                  end
                  FN_SUBU: begin
                     id_extop = 1'b1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
                     id_bundle.aluop = 2'd2; id_bundle.regwrite = 1'b1; id_bundle.dst = id_rd;
                  end
                  FN_SLT: begin
                     id_extop = 1'b1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
                     id_bundle.aluop = 2'd2; id_bundle.slt = 1'b1;
                     id_bundle.regwrite = 1'b1; id_bundle.dst = id_rd;
                  end
                  FN_JR: begin
                     id_extop = 1'b1; id_uses_rs = 1'b1; id_bundle.jr = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         OP_ORI: begin
            id_uses_rs = 1'b1;
            id_bundle.alusrc = 1'b1; id_bundle.aluop = 2'd1;
            id_bundle.regwrite = 1'b1; id_bundle.dst = id_rt;
         end
         OP_LUI: begin
            id_luiop = 1'b1;
            id_bundle.alusrc = 1'b1; id_bundle.aluop = 2'd1;
            id_bundle.regwrite = 1'b1; id_bundle.dst = id_rt;
         end
         OP_LW: begin
            id_extop = 1'b1; id_uses_rs = 1'b1;
            id_bundle.alusrc = 1'b1; id_bundle.aluop = 2'd3; id_bundle.memread = 1'b1;
            id_bundle.memtoreg = 1'b1; id_bundle.regwrite = 1'b1; id_bundle.dst = id_rt;
         end
         OP_SW: begin
            id_extop = 1'b1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
            id_bundle.alusrc = 1'b1; id_bundle.aluop = 2'd3; id_bundle.memwrite = 1'b1;
         end
         OP_BEQ: begin
            id_extop = 1'b1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
            id_bundle.aluop = 2'd2; id_bundle.beq = 1'b1;
         end
         OP_ADDI, OP_ADDIU: begin
            id_extop = 1'b1; id_uses_rs = 1'b1;
            id_bundle.alusrc = 1'b1; id_bundle.aluop = 2'd3;
            id_bundle.regwrite = 1'b1; id_bundle.dst = id_rt;
         end
         OP_J: begin
            id_extop = 1'b1; id_jump_op = 1'b1;
         end
         OP_JAL: begin
            id_extop = 1'b1; id_jump_op = 1'b1; id_bundle.link = 1'b1;
            id_bundle.regwrite = 1'b1; id_bundle.dst = REG_AW'(LINK_REG);
         end
         default: ;
      endcase
      if (id_bundle.dst == '0) id_bundle.regwrite = 1'b0;
      // Only source fields actually read are carried, so unused fields never forward.
      id_bundle.rs = id_uses_rs ? id_rs : '0;
      id_bundle.rt = id_uses_rt ? id_rt : '0;
   end

   always_comb begin
      ex_redirect = !reset && ((ex_q.beq && ex_zero) || ex_q.jr);
      ex_hit  = (ex_q.dst != '0) &&
                ((id_uses_rs && ex_q.dst == id_rs) || (id_uses_rt && ex_q.dst == id_rt));
      mem_hit = (mem_q.dst != '0) &&
                ((id_uses_rs && mem_q.dst == id_rs) || (id_uses_rt && mem_q.dst == id_rt));
      if (FWD_EN) hazard = ex_q.memread && ex_hit;
      else        hazard = (ex_q.regwrite && ex_hit) || (mem_q.regwrite && mem_hit);
      stall      = !reset && !ex_redirect && hazard;
      id_jump    = !reset && !ex_redirect && !stall && id_jump_op;
      pc_en      = !stall;
      ifid_en    = !stall;
      ifid_flush = reset || ex_redirect || id_jump;
      pc_sel     = 2'd0;
      if (ex_redirect)  pc_sel = ex_q.jr ? 2'd3 : 2'd1;
      else if (id_jump) pc_sel = 2'd2;

      fwd_a = 2'd0;
      fwd_b = 2'd0;
      if (FWD_EN) begin
         if (mem_q.regwrite && mem_q.dst != '0 && mem_q.dst == ex_q.rs)   fwd_a = 2'd2;
         else if (wb_q.regwrite && wb_q.dst != '0 && wb_q.dst == ex_q.rs) fwd_a = 2'd1;
         if (mem_q.regwrite && mem_q.dst != '0 && mem_q.dst == ex_q.rt)   fwd_b = 2'd2;
         else if (wb_q.regwrite && wb_q.dst != '0 && wb_q.dst == ex_q.rt) fwd_b = 2'd1;
      end

      ex_d           = (stall || ex_redirect) ? '0 : id_bundle;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.memread  = ex_q.memread;
      mem_d.memwrite = ex_q.memwrite;
      mem_d.memtoreg = ex_q.memtoreg;
      mem_d.dst      = ex_q.dst;
      wb_d.regwrite  = mem_q.regwrite;
      wb_d.memtoreg  = mem_q.memtoreg;
      wb_d.dst       = mem_q.dst;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign ex_alusrc   = ex_q.alusrc;
   assign ex_aluop    = ex_q.aluop;
   assign ex_slt      = ex_q.slt;
   assign ex_link     = ex_q.link;
   assign ex_dst      = ex_q.dst;
   assign mem_write   = mem_q.memwrite;
   assign mem_read    = mem_q.memread;
   assign wb_regwrite = wb_q.regwrite;
   assign wb_memtoreg = wb_q.memtoreg;
   assign wb_dst      = wb_q.dst;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode table plus multi-cycle hazard/redirect sequences.
module tb_pipe_ctrl_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] id_instr = 32'd0;
   logic [31:0] id_instr_nf = 32'd0;
   logic        ex_zero = 1'b0;

   logic       pc_en, ifid_en, ifid_flush, id_extop, id_luiop, ex_alusrc, ex_slt, ex_link;
   logic       mem_write, mem_read, wb_regwrite, wb_memtoreg;
   logic [1:0] pc_sel, ex_aluop, fwd_a, fwd_b;
   logic [4:0] ex_dst, wb_dst;

   logic       pc_en_n, ifid_en_n, ifid_flush_n, id_extop_n, id_luiop_n, ex_alusrc_n, ex_slt_n;
   logic       ex_link_n, mem_write_n, mem_read_n, wb_regwrite_n, wb_memtoreg_n;
   logic [1:0] pc_sel_n, ex_aluop_n, fwd_a_n, fwd_b_n;
   logic [4:0] ex_dst_n, wb_dst_n;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pipe_ctrl_unit #(.REG_AW(5), .FWD_EN(1'b1), .LINK_REG(31)) dut (
      .clk(clk), .reset(reset), .id_instr(id_instr), .ex_zero(ex_zero),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .pc_sel(pc_sel),
      .id_extop(id_extop), .id_luiop(id_luiop), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
      .ex_slt(ex_slt), .ex_link(ex_link), .ex_dst(ex_dst), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_write(mem_write), .mem_read(mem_read), .wb_regwrite(wb_regwrite),
      .wb_memtoreg(wb_memtoreg), .wb_dst(wb_dst));

   pipe_ctrl_unit #(.REG_AW(5), .FWD_EN(1'b0), .LINK_REG(31)) dut_nf (
      .clk(clk), .reset(reset), .id_instr(id_instr_nf), .ex_zero(1'b0),
      .pc_en(pc_en_n), .ifid_en(ifid_en_n), .ifid_flush(ifid_flush_n), .pc_sel(pc_sel_n),
      .id_extop(id_extop_n), .id_luiop(id_luiop_n), .ex_alusrc(ex_alusrc_n),
      .ex_aluop(ex_aluop_n), .ex_slt(ex_slt_n), .ex_link(ex_link_n), .ex_dst(ex_dst_n),
      .fwd_a(fwd_a_n), .fwd_b(fwd_b_n), .mem_write(mem_write_n), .mem_read(mem_read_n),
      .wb_regwrite(wb_regwrite_n), .wb_memtoreg(wb_memtoreg_n), .wb_dst(wb_dst_n));

   typedef struct {
      logic [31:0] instr;
      logic        extop, luiop, alusrc;
      logic [1:0]  aluop;
      logic        slt, link;
      logic [4:0]  dst;
      logic        memw, memr, regw, mtr;
      logic [1:0]  pid, pex;
   } vec_t;

   vec_t vecs[16];

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tgt);
      return {op, tgt};
   endfunction

   function automatic vec_t mk(input logic [31:0] ins, input logic ext, input logic lui,
                               input logic src, input logic [1:0] aop, input logic slt,
                               input logic lnk, input logic [4:0] dst, input logic mw,
                               input logic mr, input logic rw, input logic mtr,
                               input logic [1:0] pid, input logic [1:0] pex);
      vec_t v;
      v.instr = ins; v.extop = ext; v.luiop = lui; v.alusrc = src; v.aluop = aop;
      v.slt = slt; v.link = lnk; v.dst = dst; v.memw = mw; v.memr = mr; v.regw = rw;
      v.mtr = mtr; v.pid = pid; v.pex = pex;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic rst, input logic [31:0] ins, input logic z);
      @(posedge clk);
      #1;
      reset = rst;
      id_instr = ins;
      ex_zero = z;
      @(negedge clk);
   endtask

   task automatic cyc_nf(input logic [31:0] ins);
      @(posedge clk);
      #1;
      id_instr = 32'd0;
      id_instr_nf = ins;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(r_ins(1, 2, 3, 6'h21),         1,0,0,2'd3,0,0,5'd3, 0,0,1,0,2'd0,2'd0);
      vecs[1]  = mk(r_ins(3, 3, 4, 6'h23),         1,0,0,2'd2,0,0,5'd4, 0,0,1,0,2'd0,2'd0);
      vecs[2]  = mk(r_ins(1, 2, 5, 6'h2A),         1,0,0,2'd2,1,0,5'd5, 0,0,1,0,2'd0,2'd0);
      vecs[3]  = mk(i_ins(6'h0D, 1, 6, 16'h00FF),  0,0,1,2'd1,0,0,5'd6, 0,0,1,0,2'd0,2'd0);
      vecs[4]  = mk(i_ins(6'h23, 1, 7, 16'h0004),  1,0,1,2'd3,0,0,5'd7, 0,1,1,1,2'd0,2'd0);
      vecs[5]  = mk(i_ins(6'h2B, 1, 7, 16'h0008),  1,0,1,2'd3,0,0,5'd0, 1,0,0,0,2'd0,2'd0);
      vecs[6]  = mk(i_ins(6'h04, 1, 2, 16'h0010),  1,0,0,2'd2,0,0,5'd0, 0,0,0,0,2'd0,2'd0);
      vecs[7]  = mk(i_ins(6'h0F, 0, 8, 16'h1234),  0,1,1,2'd1,0,0,5'd8, 0,0,1,0,2'd0,2'd0);
      vecs[8]  = mk(i_ins(6'h08, 1, 9, 16'hFFFF),  1,0,1,2'd3,0,0,5'd9, 0,0,1,0,2'd0,2'd0);
      vecs[9]  = mk(i_ins(6'h09, 1, 10, 16'h0004), 1,0,1,2'd3,0,0,5'd10,0,0,1,0,2'd0,2'd0);
      vecs[10] = mk(j_ins(6'h02, 26'h40),          1,0,0,2'd0,0,0,5'd0, 0,0,0,0,2'd2,2'd0);
      vecs[11] = mk(j_ins(6'h03, 26'h40),          1,0,0,2'd0,0,1,5'd31,0,0,1,0,2'd2,2'd0);
      vecs[12] = mk(r_ins(5, 0, 0, 6'h08),         1,0,0,2'd0,0,0,5'd0, 0,0,0,0,2'd0,2'd3);
      vecs[13] = mk(j_ins(6'h3F, 26'h0123456),     0,0,0,2'd0,0,0,5'd0, 0,0,0,0,2'd0,2'd0);
      vecs[14] = mk(r_ins(1, 2, 0, 6'h21),         1,0,0,2'd3,0,0,5'd0, 0,0,0,0,2'd0,2'd0);
      vecs[15] = mk(r_ins(1, 2, 3, 6'h20),         0,0,0,2'd0,0,0,5'd0, 0,0,0,0,2'd0,2'd0);

      // reset state
      cyc(1, 32'd0, 0);
      cyc(1, 32'd0, 0);
      chk("rst_pc_en", pc_en, 1);
      chk("rst_ifid_en", ifid_en, 1);
      chk("rst_ifid_flush", ifid_flush, 1);
      chk("rst_pc_sel", pc_sel, 0);
      chk("rst_ex_aluop", ex_aluop, 0);
      chk("rst_ex_dst", ex_dst, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_wb_regwrite", wb_regwrite, 0);
      chk("rst_fwd_a", fwd_a, 0);
      cyc(0, 32'd0, 0);
      chk("post_rst_flush", ifid_flush, 0);

      // decode table: one instruction walked through ID, EX, MEM, WB on an empty pipe
      for (int i = 0; i < 16; i++) begin
         cyc(0, vecs[i].instr, 0);
         chk($sformatf("v%0d_extop", i), id_extop, vecs[i].extop);
         chk($sformatf("v%0d_luiop", i), id_luiop, vecs[i].luiop);
         chk($sformatf("v%0d_pcsel_id", i), pc_sel, vecs[i].pid);
         chk($sformatf("v%0d_flush_id", i), ifid_flush, vecs[i].pid != 2'd0);
         chk($sformatf("v%0d_pc_en", i), pc_en, 1);
         cyc(0, 32'd0, 0);
         chk($sformatf("v%0d_alusrc", i), ex_alusrc, vecs[i].alusrc);
         chk($sformatf("v%0d_aluop", i), ex_aluop, vecs[i].aluop);
         chk($sformatf("v%0d_slt", i), ex_slt, vecs[i].slt);
         chk($sformatf("v%0d_link", i), ex_link, vecs[i].link);
         chk($sformatf("v%0d_ex_dst", i), ex_dst, vecs[i].dst);
         chk($sformatf("v%0d_pcsel_ex", i), pc_sel, vecs[i].pex);
         chk($sformatf("v%0d_flush_ex", i), ifid_flush, vecs[i].pex != 2'd0);
         cyc(0, 32'd0, 0);
         chk($sformatf("v%0d_mem_write", i), mem_write, vecs[i].memw);
         chk($sformatf("v%0d_mem_read", i), mem_read, vecs[i].memr);
         cyc(0, 32'd0, 0);
         chk($sformatf("v%0d_wb_regwrite", i), wb_regwrite, vecs[i].regw);
         chk($sformatf("v%0d_wb_memtoreg", i), wb_memtoreg, vecs[i].mtr);
         if (vecs[i].regw) chk($sformatf("v%0d_wb_dst", i), wb_dst, vecs[i].dst);
      end
      cyc(0, 32'd0, 0);

      // T1: reset for 3 cycles while lw r8 is in EX
      cyc(0, i_ins(6'h23, 1, 8, 16'h0000), 0);
      cyc(1, j_ins(6'h03, 26'h80), 0);
      chk("t1_lw_in_ex", ex_dst, 8);
      chk("t1_rst_pc_sel", pc_sel, 0);
      chk("t1_rst_flush", ifid_flush, 1);
      chk("t1_rst_pc_en", pc_en, 1);
      cyc(1, j_ins(6'h03, 26'h80), 0);
      chk("t1_ex_cleared", ex_dst, 0);
      chk("t1_mem_read", mem_read, 0);
      cyc(1, 32'd0, 0);
      cyc(0, 32'd0, 0);
      chk("t1_wb_regwrite", wb_regwrite, 0);
      chk("t1_mem_write", mem_write, 0);
      chk("t1_pc_sel", pc_sel, 0);
      chk("t1_pc_en", pc_en, 1);
      chk("t1_flush", ifid_flush, 0);
      cyc(0, 32'd0, 0);
      chk("t1_wb_regwrite2", wb_regwrite, 0);

      // T2: lw r8,0(r0); addu r9,r8,r8
      cyc(0, i_ins(6'h23, 0, 8, 16'h0000), 0);
      chk("t2_no_stall_lw", pc_en, 1);
      cyc(0, r_ins(8, 8, 9, 6'h21), 0);
      chk("t2_stall_pc_en", pc_en, 0);
      chk("t2_stall_ifid_en", ifid_en, 0);
      cyc(0, r_ins(8, 8, 9, 6'h21), 0);
      chk("t2_release_pc_en", pc_en, 1);
      chk("t2_bubble_ex", ex_dst, 0);
      chk("t2_lw_mem_read", mem_read, 1);
      cyc(0, 32'd0, 0);
      chk("t2_fwd_a", fwd_a, 1);
      chk("t2_fwd_b", fwd_b, 1);
      chk("t2_ex_dst", ex_dst, 9);
      chk("t2_wb_dst", wb_dst, 8);
      chk("t2_wb_memtoreg", wb_memtoreg, 1);
      repeat (3) cyc(0, 32'd0, 0);

      // T3: addu r3,r1,r2; subu r4,r3,r3; ori r5,r3,1 (MEM then WB forwarding)
      cyc(0, r_ins(1, 2, 3, 6'h21), 0);
      cyc(0, r_ins(3, 3, 4, 6'h23), 0);
      chk("t3_no_stall", pc_en, 1);
      cyc(0, i_ins(6'h0D, 3, 5, 16'h0001), 0);
      chk("t3_fwd_a_mem", fwd_a, 2);
      chk("t3_fwd_b_mem", fwd_b, 2);
      cyc(0, 32'd0, 0);
      chk("t3_fwd_a_wb", fwd_a, 1);
      chk("t3_fwd_b_none", fwd_b, 0);
      // MEM wins over WB when both target r3
      cyc(0, r_ins(1, 2, 3, 6'h21), 0);
      cyc(0, r_ins(3, 3, 3, 6'h21), 0);
      cyc(0, r_ins(3, 0, 6, 6'h23), 0);
      cyc(0, 32'd0, 0);
      chk("t3_prio_fwd_a", fwd_a, 2);
      chk("t3_prio_fwd_b", fwd_b, 0);
      // r0 is never a forwarding source
      cyc(0, r_ins(1, 2, 0, 6'h21), 0);
      cyc(0, r_ins(0, 0, 7, 6'h21), 0);
      cyc(0, 32'd0, 0);
      chk("t3_r0_fwd_a", fwd_a, 0);
      chk("t3_r0_fwd_b", fwd_b, 0);
      repeat (3) cyc(0, 32'd0, 0);

      // T3 without forwarding: two interlock cycles, none against WB
      cyc_nf(r_ins(1, 2, 3, 6'h21));
      cyc_nf(r_ins(3, 3, 4, 6'h23));
      chk("t3nf_stall1", pc_en_n, 0);
      cyc_nf(r_ins(3, 3, 4, 6'h23));
      chk("t3nf_stall2", pc_en_n, 0);
      cyc_nf(r_ins(3, 3, 4, 6'h23));
      chk("t3nf_release", pc_en_n, 1);
      cyc_nf(32'd0);
      chk("t3nf_ex_dst", ex_dst_n, 4);
      chk("t3nf_fwd_a", fwd_a_n, 0);
      chk("t3nf_fwd_b", fwd_b_n, 0);
      repeat (3) cyc_nf(32'd0);
      // redirect in EX overrides a RAW stall on the ID instruction
      cyc_nf(r_ins(1, 2, 3, 6'h21));
      cyc_nf(r_ins(1, 0, 0, 6'h08));
      chk("t3nf_jr_no_stall", pc_en_n, 1);
      cyc_nf(r_ins(3, 3, 12, 6'h21));
      chk("t3nf_redir_pc_sel", pc_sel_n, 3);
      chk("t3nf_redir_pc_en", pc_en_n, 1);
      chk("t3nf_redir_flush", ifid_flush_n, 1);
      cyc_nf(32'd0);
      chk("t3nf_squash", ex_dst_n, 0);
      repeat (3) cyc_nf(32'd0);

      // T4: taken beq squashes the instruction in ID
      cyc(0, i_ins(6'h04, 1, 1, 16'h0004), 0);
      cyc(0, r_ins(1, 2, 11, 6'h21), 1);
      chk("t4_pc_sel", pc_sel, 1);
      chk("t4_flush", ifid_flush, 1);
      chk("t4_pc_en", pc_en, 1);
      cyc(0, 32'd0, 0);
      chk("t4_bubble", ex_dst, 0);
      chk("t4_pc_sel_after", pc_sel, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 32'd0, 0);
         chk($sformatf("t4_no_write%0d", k), wb_regwrite, 0);
      end

      // T5: load-use stall, then jal in ID
      cyc(0, i_ins(6'h23, 0, 8, 16'h0000), 0);
      cyc(0, r_ins(8, 8, 9, 6'h21), 0);
      chk("t5_stall", pc_en, 0);
      cyc(0, r_ins(8, 8, 9, 6'h21), 0);
      chk("t5_release", pc_en, 1);
      chk("t5_no_jump_yet", pc_sel, 0);
      cyc(0, j_ins(6'h03, 26'h100), 0);
      chk("t5_pc_sel_jal", pc_sel, 2);
      chk("t5_flush_jal", ifid_flush, 1);
      chk("t5_fwd_a", fwd_a, 1);
      cyc(0, 32'd0, 0);
      chk("t5_ex_link", ex_link, 1);
      chk("t5_ex_dst", ex_dst, 31);
      chk("t5_pc_sel_after", pc_sel, 0);
      cyc(0, 32'd0, 0);
      cyc(0, 32'd0, 0);
      chk("t5_wb_dst", wb_dst, 31);
      chk("t5_wb_regwrite", wb_regwrite, 1);

      // T6: jr in EX beats jal / j in ID
      cyc(0, r_ins(5, 0, 0, 6'h08), 0);
      cyc(0, j_ins(6'h03, 26'h200), 0);
      chk("t6_pc_sel", pc_sel, 3);
      chk("t6_flush", ifid_flush, 1);
      chk("t6_pc_en", pc_en, 1);
      cyc(0, 32'd0, 0);
      chk("t6_link_squashed", ex_link, 0);
      chk("t6_dst_squashed", ex_dst, 0);
      cyc(0, 32'd0, 0);
      cyc(0, 32'd0, 0);
      chk("t6_no_wb", wb_regwrite, 0);
      cyc(0, r_ins(5, 0, 0, 6'h08), 0);
      cyc(0, j_ins(6'h02, 26'h200), 0);
      chk("t6_j_pc_sel", pc_sel, 3);
      cyc(0, 32'd0, 0);
      chk("t6_j_pc_sel_after", pc_sel, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
